reg_writeback: RTL and testbench

- Writeback arbiter directly upstream of the 32x32 register file.
- Merges two result sources onto the file's single write port (wr/select/data): the ALU result and memory-load results.
- Loads arrive with a valid/ready handshake and are buffered in a small FIFO.
- ALU results have priority, with a starvation guard so buffered loads always drain.

---
 rtl/reg_writeback.sv | 62 ++++++
 tb/tb_reg_writeback.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// reg_writeback: arbitrates ALU results and FIFO-buffered loads onto the register-file write port
module reg_writeback #(
  parameter int WIDTH = 32,
  parameter int ABITS = 5,
  parameter int DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [ABITS-1:0] alu_dest,
  input  logic [WIDTH-1:0] alu_data,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [ABITS-1:0] ld_dest,
  input  logic [WIDTH-1:0] ld_data,
  output logic             rf_wr,
  output logic [ABITS-1:0] rf_select,
  output logic [WIDTH-1:0] rf_data,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  logic [ABITS+WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;
  logic nonempty, push, pop, alu_win;
  assign nonempty  = count != '0;
  assign ld_ready  = count < FULL;
  assign alu_ready = !(nonempty && starve_cnt == SMAX);
  assign alu_win   = alu_valid && alu_ready;
  assign pop       = !alu_win && nonempty;
  assign push      = ld_valid && ld_ready;
  assign busy      = nonempty || rf_wr;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {ld_dest, ld_data};
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      rf_wr      <= 1'b0;
      rf_select  <= '0;
      rf_data    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count      <= count + CW'(push) - CW'(pop);
      starve_cnt <= (pop || !nonempty) ? '0 :
                    (alu_win && starve_cnt != SMAX) ? starve_cnt + SW'(1) : starve_cnt;
      rf_wr      <= alu_win || pop;
      if (alu_win) {rf_select, rf_data} <= {alu_dest, alu_data};
      else if (pop) {rf_select, rf_data} <= mem[rd_ptr];
    end
  end
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed checks of writeback arbitration, FIFO backpressure, starvation guard and reset
module tb_reg_writeback;
  logic        clk = 0;
  logic        rst;
  logic        alu_valid, alu_ready, ld_valid, ld_ready, rf_wr, busy;
  logic [4:0]  alu_dest, ld_dest, rf_select;
  logic [31:0] alu_data, ld_data, rf_data;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  reg_writeback dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dest(ld_dest), .ld_data(ld_data),
    .rf_wr(rf_wr), .rf_select(rf_select), .rf_data(rf_data), .busy(busy)
  );
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_wr(input string tag, input logic [4:0] sel, input logic [31:0] dat);
    chk({tag, "_wr"}, 32'(rf_wr), 32'd1);
    chk({tag, "_sel"}, 32'(rf_select), 32'(sel));
    chk({tag, "_data"}, rf_data, dat);
  endtask
  task automatic do_reset;
    rst = 1;
    tick();
    rst = 0;
  endtask
  initial begin
    rst = 0; alu_valid = 0; alu_dest = 0; alu_data = 0;
    ld_valid = 0; ld_dest = 0; ld_data = 0;
    do_reset();
    chk("rst_wr", 32'(rf_wr), 0);
    chk("rst_sel", 32'(rf_select), 0);
    chk("rst_data", rf_data, 0);
    chk("rst_ldr", 32'(ld_ready), 1);
    chk("rst_alur", 32'(alu_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    // ALU only
    alu_valid = 1; alu_dest = 3; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 0;
    chk_wr("alu1", 3, 32'hDEADBEEF);
    tick();
    chk("alu2_wr", 32'(rf_wr), 0);
    chk("alu2_sel", 32'(rf_select), 3);
    chk("alu2_data", rf_data, 32'hDEADBEEF);
    chk("alu2_busy", 32'(busy), 0);
    // idle load: two-cycle latency
    ld_valid = 1; ld_dest = 7; ld_data = 32'h12345678;
    chk("ld0_ready", 32'(ld_ready), 1);
    tick();
    ld_valid = 0;
    chk("ld1_wr", 32'(rf_wr), 0);
    chk("ld1_busy", 32'(busy), 1);
    tick();
    chk_wr("ld2", 7, 32'h12345678);
    chk("ld2_busy", 32'(busy), 1);
    tick();
    chk("ld3_wr", 32'(rf_wr), 0);
    chk("ld3_busy", 32'(busy), 0);
    // FIFO full under continuous ALU traffic
    alu_valid = 1; alu_dest = 20; alu_data = 32'h100;
    ld_valid = 1; ld_dest = 10; ld_data = 32'hA1;
    chk("full0_ready", 32'(ld_ready), 1);
    tick();
    ld_dest = 11; ld_data = 32'hA2;
    chk("full1_ready", 32'(ld_ready), 1);
    chk_wr("full1_alu", 20, 32'h100);
    tick();
    ld_dest = 12; ld_data = 32'hA3;
    chk("full2_ready", 32'(ld_ready), 0);
    tick(3);
    chk("full5_alur", 32'(alu_ready), 0);
    chk("full5_ldr", 32'(ld_ready), 0);
    tick();
    chk_wr("full6_a1", 10, 32'hA1);
    chk("full6_ldr", 32'(ld_ready), 1);
    chk("full6_alur", 32'(alu_ready), 1);
    tick();
    ld_valid = 0;
    chk_wr("full7_alu", 20, 32'h100);
    tick(3);
    chk("full10_alur", 32'(alu_ready), 0);
    tick();
    chk_wr("full11_a2", 11, 32'hA2);
    tick(4);
    chk("full15_alur", 32'(alu_ready), 0);
    tick();
    chk_wr("full16_a3", 12, 32'hA3);
    alu_valid = 0;
    tick();
    chk("full17_wr", 32'(rf_wr), 0);
    chk("full17_busy", 32'(busy), 0);
    // starvation guard with one buffered load
    ld_valid = 1; ld_dest = 9; ld_data = 32'h99;
    tick();
    ld_valid = 0;
    alu_valid = 1; alu_dest = 4; alu_data = 32'h44;
    chk("st1_alur", 32'(alu_ready), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_wr($sformatf("st_alu%0d", i), 4, 32'h44);
    end
    chk("st5_alur", 32'(alu_ready), 0);
    tick();
    chk_wr("st6_ld", 9, 32'h99);
    chk("st6_alur", 32'(alu_ready), 1);
    tick();
    chk_wr("st7_alu", 4, 32'h44);
    alu_valid = 0;
    tick();
    chk("st8_wr", 32'(rf_wr), 0);
    // simultaneous ALU and load, destination 0 passes through on a later write
    alu_valid = 1; alu_dest = 1; alu_data = 32'h11;
    ld_valid = 1; ld_dest = 2; ld_data = 32'h22;
    tick();
    alu_valid = 0; ld_valid = 0;
    chk_wr("sim1", 1, 32'h11);
    tick();
    chk_wr("sim2", 2, 32'h22);
    alu_valid = 1; alu_dest = 0; alu_data = 32'h5A5A;
    tick();
    alu_valid = 0;
    chk_wr("dest0", 0, 32'h5A5A);
    tick();
    // reset mid-operation with a full FIFO
    alu_valid = 1; alu_dest = 5; alu_data = 32'h55;
    ld_valid = 1; ld_dest = 13; ld_data = 32'hB1;
    tick();
    ld_dest = 14; ld_data = 32'hB2;
    tick();
    ld_valid = 0; alu_valid = 0;
    chk("rm_full", 32'(ld_ready), 0);
    do_reset();
    chk("rm_wr", 32'(rf_wr), 0);
    chk("rm_ldr", 32'(ld_ready), 1);
    chk("rm_busy", 32'(busy), 0);
    chk("rm_sel", 32'(rf_select), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rm_idle%0d", i), 32'(rf_wr), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
